// File: rtl/cgra0_thread_sched.sv
// Run controller for the cgra0 PE array: per-thread quotas, array enable, drain and done pulse.
// Defining CGRA0_SCHED_STALL_EN lets in_avail/out_full gate en; otherwise they are ignored.
module cgra0_thread_sched #(
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned QTD_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 qtd_we,
    input  logic [2:0]           qtd_thread,
    input  logic [QTD_WIDTH-1:0] qtd_data,
    input  logic                 in_avail,
    input  logic                 out_full,
    output logic                 en,
    output logic [2:0]           thread_slot,
    output logic [7:0]           thread_active,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned NUM_THREADS = 8;
    localparam int unsigned DRAIN_W     = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [QTD_WIDTH-1:0]   count      [NUM_THREADS];
    logic [QTD_WIDTH-1:0]   count_next [NUM_THREADS];
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [DRAIN_W-1:0]     drain_cnt_next;
    logic [2:0]             slot_next;
    logic [NUM_THREADS-1:0] active_next;
    logic                   run_ok;
    logic                   drain_ok;

`ifdef CGRA0_SCHED_STALL_EN
    assign run_ok   = in_avail & ~out_full;
    assign drain_ok = ~out_full;
`else
    logic unused_stall;
    assign unused_stall = in_avail | out_full;
    assign run_ok       = 1'b1;
    assign drain_ok     = 1'b1;
`endif

    // Next state, array enable and next datapath values.
    always_comb begin
        state_next     = state;
        en             = 1'b0;
        slot_next      = thread_slot;
        drain_cnt_next = drain_cnt;
        active_next    = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            count_next[i] = count[i];
        end

        case (state)
            ST_IDLE: begin
                if (qtd_we) begin
                    count_next[qtd_thread] = qtd_data;
                end
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                en = (thread_active != '0) && run_ok;
                // Zero-count slots are still issued as bubbles to keep PE threads aligned.
                if (en && (count[thread_slot] != '0)) begin
                    count_next[thread_slot] = count[thread_slot] - QTD_WIDTH'(1);
                end
                if (thread_active == '0) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                en = drain_ok;
                if (en) begin
                    drain_cnt_next = drain_cnt - DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The slot tracks every enabled cycle, since PE thread counters only reset on rst.
        if (en) begin
            slot_next = thread_slot + 3'd1;
        end

        if (abort && ((state == ST_RUN) || (state == ST_DRAIN))) begin
            state_next     = ST_IDLE;
            drain_cnt_next = '0;
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                count_next[i] = '0;
            end
        end

        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            active_next[i] = (count_next[i] != '0);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts, slot, drain counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thread_slot   <= '0;
            drain_cnt     <= '0;
            thread_active <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                count[i] <= '0;
            end
        end else begin
            thread_slot   <= slot_next;
            drain_cnt     <= drain_cnt_next;
            thread_active <= active_next;
            busy          <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            done          <= (state_next == ST_DONE);
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                count[i] <= count_next[i];
            end
        end
    end

endmodule
